// File: rtl/cache_line_fill.sv
// Miss handler for the fully-associative cache: picks a victim line, writes it
// back when dirty, refills it from memory and updates the tag/data arrays.
module cache_line_fill #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int NUM_LINES     = 4,
    localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8),
    localparam int LINE_IDX     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int TAG_WIDTH    = ADDRESS_WIDTH - OFFSET_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_req,
    input  logic [ADDRESS_WIDTH-1:0] miss_addr,
    output logic                     miss_busy,
    output logic                     fill_done,
    output logic [LINE_IDX-1:0]      fill_line,
    input  logic [NUM_LINES-1:0]     line_valid,
    input  logic [NUM_LINES-1:0]     line_dirty,
    input  logic [TAG_WIDTH-1:0]     victim_tag,
    input  logic [LINE_WIDTH-1:0]    victim_data,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ready,
    input  logic [LINE_WIDTH-1:0]    mem_rdata,
    output logic                     tag_we,
    output logic [TAG_WIDTH-1:0]     tag_wdata,
    output logic [LINE_WIDTH-1:0]    data_wdata
);

    typedef enum logic [1:0] {IDLE, WB, RF, UPD} state_t;

    state_t                state;
    logic [LINE_IDX-1:0]   rr_ptr;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic [LINE_IDX-1:0]   victim;
    logic                  all_valid;
    logic                  unused_offset;

    // Byte offset within the line never matters for a line fill.
    assign unused_offset = ^miss_addr[OFFSET_WIDTH-1:0];

    // Lowest-index invalid line wins; round-robin only when every line is valid.
    always_comb begin
        victim    = rr_ptr;
        all_valid = 1'b1;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!line_valid[i]) begin
                victim    = LINE_IDX'(i);
                all_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            fill_line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        tag_q     <= miss_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                        fill_line <= victim;
                        if (all_valid) begin
                            rr_ptr <= LINE_IDX'(rr_ptr + 1'b1);
                        end
                        state <= (line_valid[victim] && line_dirty[victim]) ? WB : RF;
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        state <= RF;
                    end
                end
                RF: begin
                    if (mem_ready) begin
                        data_q <= mem_rdata;
                        state  <= UPD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so no input reaches them combinationally
    // except the array read-back that the writeback forwards.
    always_comb begin
        miss_busy  = (state != IDLE);
        mem_req    = (state == WB) || (state == RF);
        mem_write  = (state == WB);
        fill_done  = (state == UPD);
        tag_we     = (state == UPD);
        mem_addr   = '0;
        mem_wdata  = '0;
        tag_wdata  = '0;
        data_wdata = '0;
        case (state)
            WB: begin
                mem_addr  = {victim_tag, {OFFSET_WIDTH{1'b0}}};
                mem_wdata = victim_data;
            end
            RF: begin
                mem_addr = {tag_q, {OFFSET_WIDTH{1'b0}}};
            end
            UPD: begin
                tag_wdata  = tag_q;
                data_wdata = data_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: a queue-based cache/memory model predicts
// every memory transaction and array update; a monitor compares as they appear.
module tb_cache_line_fill;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         miss_busy;
    logic         fill_done;
    logic [1:0]   fill_line;
    logic [3:0]   line_valid;
    logic [3:0]   line_dirty;
    logic [27:0]  victim_tag;
    logic [127:0] victim_data;
    logic         mem_req;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic         tag_we;
    logic [27:0]  tag_wdata;
    logic [127:0] data_wdata;

    logic [27:0]  tag_arr[4];
    logic [127:0] data_arr[4];
    logic         ready_mem;
    logic         ready_poke;
    int           wait_cfg;
    logic         sb_off;
    int           n_checks = 0;
    int           n_pass = 0;
    int           rr = 0;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mem_t;
    typedef struct {
        logic [1:0]   line;
        logic [27:0]  tag;
        logic [127:0] data;
    } fill_t;
    mem_t  mq[$];
    fill_t fq[$];

    assign mem_ready   = ready_mem | ready_poke;
    assign victim_tag  = tag_arr[fill_line];
    assign victim_data = data_arr[fill_line];

    always #5 clk = ~clk;

    cache_line_fill dut (
        .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_busy(miss_busy), .fill_done(fill_done), .fill_line(fill_line),
        .line_valid(line_valid), .line_dirty(line_dirty), .victim_tag(victim_tag),
        .victim_data(victim_data), .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .tag_we(tag_we), .tag_wdata(tag_wdata),
        .data_wdata(data_wdata)
    );

    function automatic logic [127:0] mem_fn(input logic [31:0] a);
        return {a ^ 32'h1111_1111, a * 32'd3, ~a, a + 32'h0000_dead};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got event, expected none/other", name);
    endtask

    // Memory: each request completes after a configured or random number of wait cycles.
    initial begin
        int  wcnt;
        logic in_req;
        ready_mem = 1'b0;
        mem_rdata = '0;
        in_req    = 1'b0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            ready_mem = 1'b0;
            if (!mem_req) begin
                in_req = 1'b0;
            end else begin
                if (!in_req) begin
                    wcnt   = (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 3));
                    in_req = 1'b1;
                end
                if (wcnt == 0) begin
                    ready_mem = 1'b1;
                    mem_rdata = mem_fn(mem_addr);
                    in_req    = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Monitor: pops expectations when a request completes or the arrays are written.
    initial begin
        mem_t  m;
        fill_t f;
        forever begin
            @(negedge clk);
            #2;
            if (tag_we || fill_done) chk("tag_we_vs_fill_done", tag_we, fill_done);
            if (!sb_off && mem_req && mem_ready) begin
                if (mq.size() == 0) begin
                    fail_now("mem_unexpected");
                end else begin
                    m = mq.pop_front();
                    chk("mem_write", mem_write, m.wr);
                    chk("mem_addr", mem_addr, m.addr);
                    if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
            if (!sb_off && fill_done) begin
                if (fq.size() == 0) begin
                    fail_now("fill_unexpected");
                end else begin
                    f = fq.pop_front();
                    chk("fill_line", fill_line, f.line);
                    chk("tag_wdata", tag_wdata, f.tag);
                    chk("data_wdata", data_wdata, f.data);
                end
            end
        end
    end

    // Reference model of one miss: victim choice, expected traffic, array update.
    task automatic do_miss(input logic [31:0] addr, input int change_at, output int lat);
        int          v;
        logic [31:0] la;
        v = -1;
        for (int i = 0; i < 4; i++) if (v < 0 && !line_valid[i]) v = i;
        if (v < 0) begin
            v  = rr;
            rr = (rr + 1) % 4;
        end
        if (line_valid[v] && line_dirty[v])
            mq.push_back('{1'b1, {tag_arr[v], 4'h0}, data_arr[v]});
        la = {addr[31:4], 4'h0};
        mq.push_back('{1'b0, la, 128'h0});
        fq.push_back('{2'(v), addr[31:4], mem_fn(la)});
        miss_req  = 1'b1;
        miss_addr = addr;
        lat       = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == change_at) miss_addr = $urandom;
            if (fill_done) break;
            if (lat > 60) begin
                fail_now("fill_timeout");
                break;
            end
        end
        miss_req      = 1'b0;
        line_valid[v] = 1'b1;
        line_dirty[v] = 1'b0;
        tag_arr[v]    = addr[31:4];
        data_arr[v]   = mem_fn(la);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rr    = 0;
    endtask

    initial begin
        int          lat;
        logic [1:0]  fl;
        reset      = 1'b1;
        miss_req   = 1'b0;
        miss_addr  = '0;
        line_valid = 4'h0;
        line_dirty = 4'h0;
        ready_poke = 1'b0;
        wait_cfg   = 0;
        sb_off     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tag_arr[i]  = 28'($urandom);
            data_arr[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_miss_busy", miss_busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_tag_we", tag_we, 0);
        chk("rst_fill_line", fill_line, 0);
        chk("rst_mem_addr", mem_addr, 0);

        // All invalid, refill completes on the third RF cycle.
        wait_cfg = 2;
        do_miss(32'h0000_1234, 0, lat);
        chk("lat_wait2", lat, 4);

        // All valid and clean: round-robin victims 0,1,2,3,0 with no writeback.
        wait_cfg   = 0;
        line_valid = 4'hF;
        line_dirty = 4'h0;
        for (int k = 0; k < 5; k++) begin
            do_miss($urandom, 0, lat);
            chk("lat_clean", lat, 2);
        end

        // Dirty victim 0 is written back before the refill.
        pulse_reset();
        line_valid = 4'hF;
        line_dirty = 4'h1;
        tag_arr[0] = 28'hABCDEF0;
        do_miss($urandom, 0, lat);
        chk("lat_dirty", lat, 3);

        // rr_ptr is 1 here: an invalid line is chosen without advancing it.
        line_valid = 4'b1011;
        line_dirty = 4'h0;
        do_miss($urandom, 0, lat);
        line_valid = 4'hF;
        do_miss($urandom, 0, lat);

        // Stray mem_ready in IDLE; miss_addr change while refilling is ignored.
        fl         = fill_line;
        ready_poke = 1'b1;
        @(negedge clk);
        ready_poke = 1'b0;
        @(negedge clk);
        chk("poke_busy", miss_busy, 0);
        chk("poke_mem_req", mem_req, 0);
        chk("poke_fill_line", fill_line, fl);
        wait_cfg = 3;
        do_miss($urandom, 2, lat);

        // Reset while refilling abandons the fill.
        sb_off     = 1'b1;
        wait_cfg   = 5;
        line_valid = 4'hF;
        line_dirty = 4'h0;
        miss_req   = 1'b1;
        miss_addr  = $urandom;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mem_req", mem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_busy", miss_busy, 0);
        chk("midrst_tag_we", tag_we, 0);
        reset    = 1'b0;
        miss_req = 1'b0;
        rr       = 0;
        @(negedge clk);
        chk("midrst_idle_tag_we", tag_we, 0);
        sb_off   = 1'b0;
        wait_cfg = 0;
        do_miss($urandom, 0, lat);
        chk("post_rst_lat", lat, 2);

        // Randomized misses with random masks, dirtiness and memory latency.
        wait_cfg = -1;
        for (int k = 0; k < 40; k++) begin
            line_valid = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            line_dirty = 4'($urandom);
            do_miss($urandom, 0, lat);
        end

        repeat (3) @(negedge clk);
        chk("mem_queue_drained", 32'(mq.size()), 0);
        chk("fill_queue_drained", 32'(fq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
